// File: rtl/alu_issue_ctrl_pkg.sv
// Shared encodings for the EX-stage ALU issue controller: ALU Operation codes,
// ALUOp classes and the funct3 values the decoder recognises.
package alu_issue_ctrl_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    // Operations whose result is a two's-complement sum and can overflow.
    function automatic logic is_arith(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct decoder producing the ALU Operation code, the
// carry-in and an illegal flag for unsupported funct combinations.
module alu_op_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       f7b5,
    output logic [3:0] operation,
    output logic       carry_in,
    output logic       illegal
);

    always_comb begin
        operation = OP_AND;
        illegal   = 1'b0;
        case (aluop)
            ALUOP_MEM:    operation = OP_ADD;
            ALUOP_BRANCH: operation = OP_SUB;
            default: begin
                case (funct3)
                    // f7b5 only distinguishes SUB for register-register forms
                    F3_ADD:  operation = (aluop == ALUOP_RTYPE && f7b5) ? OP_SUB : OP_ADD;
                    F3_AND:  operation = OP_AND;
                    F3_OR:   operation = OP_OR;
                    F3_SLT:  operation = OP_SLT;
                    default: illegal   = 1'b1;
                endcase
            end
        endcase
    end

    assign carry_in = (operation == OP_SUB) || (operation == OP_SLT);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-stage issue controller for the EX-stage ALU: S1 drives the ALU operands,
// S2 captures the result and flags and hands them downstream.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [1:0]   in_aluop,
    input  logic [2:0]   in_funct3,
    input  logic         in_funct7b5,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_operation,
    output logic         alu_carry_in,
    input  logic [N-1:0] alu_result,
    input  logic         alu_carry_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic         out_zero,
    output logic         out_overflow,
    output logic         out_illegal
);

    logic       s1_valid;
    logic       s1_illegal;
    logic       s1_adv;
    logic       s1_load;
    logic [3:0] dec_operation;
    logic       dec_carry_in;
    logic       dec_illegal;

    // Overflow is derived from operand/result signs, so carry-out is not needed.
    logic unused_carry_out;
    assign unused_carry_out = alu_carry_out;

    alu_op_decode u_decode (
        .aluop     (in_aluop),
        .funct3    (in_funct3),
        .f7b5      (in_funct7b5),
        .operation (dec_operation),
        .carry_in  (dec_carry_in),
        .illegal   (dec_illegal)
    );

    assign s1_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s1_adv;
    assign s1_load  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_illegal    <= 1'b0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_operation <= OP_AND;
            alu_carry_in  <= 1'b0;
        end else if (s1_load) begin
            s1_valid      <= 1'b1;
            s1_illegal    <= dec_illegal;
            alu_a         <= in_a;
            alu_b         <= in_b;
            alu_operation <= dec_operation;
            alu_carry_in  <= dec_carry_in;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    logic         b_eff_msb;
    logic         ovf;
    logic         slt;
    logic [N-1:0] result_next;

    // Only the sign bit of the effective (possibly inverted) B operand matters.
    assign b_eff_msb = alu_carry_in ^ alu_b[N-1];
    assign ovf = is_arith(alu_operation)
               && (alu_a[N-1] == b_eff_msb)
               && (alu_result[N-1] != alu_a[N-1]);
    assign slt = alu_result[N-1] ^ ovf;

    always_comb begin
        result_next = alu_result;
        if (alu_operation == OP_SLT) begin
            result_next = {{(N-1){1'b0}}, slt};
        end else if (s1_illegal) begin
            result_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (s1_adv) begin
            out_valid    <= 1'b1;
            out_result   <= result_next;
            out_zero     <= (result_next == '0);
            out_overflow <= ovf;
            out_illegal  <= s1_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a behavioural ALU closes the loop, a
// reference model predicts each accepted item and a monitor checks outputs.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [1:0]   in_aluop;
    logic [2:0]   in_funct3;
    logic         in_funct7b5;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_operation;
    logic         alu_carry_in;
    logic [N-1:0] alu_result;
    logic         alu_carry_out;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_result;
    logic         out_zero;
    logic         out_overflow;
    logic         out_illegal;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.N(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_aluop      (in_aluop),
        .in_funct3     (in_funct3),
        .in_funct7b5   (in_funct7b5),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_operation (alu_operation),
        .alu_carry_in  (alu_carry_in),
        .alu_result    (alu_result),
        .alu_carry_out (alu_carry_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_zero      (out_zero),
        .out_overflow  (out_overflow),
        .out_illegal   (out_illegal)
    );

    // Behavioural ALU; SUB/SLT rely on the controller's carry-in for the +1.
    always_comb begin
        alu_result    = '0;
        alu_carry_out = 1'b0;
        case (alu_operation)
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_NOR:  alu_result = ~(alu_a | alu_b);
            OP_NAND: alu_result = ~(alu_a & alu_b);
            OP_ADD:  {alu_carry_out, alu_result} = {1'b0, alu_a} + {1'b0, alu_b}
                                                  + {{N{1'b0}}, alu_carry_in};
            OP_SUB, OP_SLT:
                     {alu_carry_out, alu_result} = {1'b0, alu_a} + {1'b0, ~alu_b}
                                                  + {{N{1'b0}}, alu_carry_in};
            default: ;
        endcase
    end

    typedef struct {
        logic [N-1:0] result;
        logic         zero;
        logic         ovf;
        logic         ill;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         n_out  = 0;
    bit         pend_valid = 1'b0;
    logic [3:0] pend_op;
    logic       pend_cin;
    bit         use_override = 1'b0;
    exp_t       override;

    task automatic chk(input bit ok, input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic void ref_decode(input logic [1:0] aluop, input logic [2:0] f3, input logic f7,
                                       output logic [3:0] op, output logic ill);
        ill = 1'b0;
        op  = OP_AND;
        if (aluop == 2'b00)      op = OP_ADD;
        else if (aluop == 2'b01) op = OP_SUB;
        else if (f3 == 3'b000)   op = (aluop == 2'b10 && f7) ? OP_SUB : OP_ADD;
        else if (f3 == 3'b111)   op = OP_AND;
        else if (f3 == 3'b110)   op = OP_OR;
        else if (f3 == 3'b010)   op = OP_SLT;
        else                     ill = 1'b1;
    endfunction

    function automatic exp_t ref_model(input logic [3:0] op, input logic ill,
                                       input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t         e;
        logic [N-1:0] d;
        e.ovf = 1'b0;
        d     = a - b;
        case (op)
            OP_ADD: begin
                e.result = a + b;
                e.ovf    = (a[N-1] == b[N-1]) && (e.result[N-1] != a[N-1]);
            end
            OP_SUB: begin
                e.result = d;
                e.ovf    = (a[N-1] != b[N-1]) && (d[N-1] != a[N-1]);
            end
            OP_SLT: begin
                e.result = ($signed(a) < $signed(b)) ? {{(N-1){1'b0}}, 1'b1} : '0;
                e.ovf    = (a[N-1] != b[N-1]) && (d[N-1] != a[N-1]);
            end
            OP_OR:   e.result = a | b;
            default: e.result = a & b;
        endcase
        if (ill) e.result = '0;
        e.ill  = ill;
        e.zero = (e.result == '0);
        return e;
    endfunction

    // One cycle of stimulus: inputs change at the falling edge, handshake at the next rising edge.
    task automatic drive(input bit v, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [1:0] aluop, input logic [2:0] f3, input logic f7,
                         input bit ordy, output bit acc);
        logic [3:0] op;
        logic       ill;
        @(negedge clk);
        in_valid = v; in_a = a; in_b = b;
        in_aluop = aluop; in_funct3 = f3; in_funct7b5 = f7;
        out_ready = ordy;
        #1;
        if (pend_valid) begin
            chk(alu_operation === pend_op, "issue_operation", N'(alu_operation), N'(pend_op));
            chk(alu_carry_in === pend_cin, "issue_carry_in", N'(alu_carry_in), N'(pend_cin));
        end
        pend_valid = 1'b0;
        acc = v && (in_ready === 1'b1);
        if (acc) begin
            ref_decode(aluop, f3, f7, op, ill);
            q.push_back(use_override ? override : ref_model(op, ill, a, b));
            pend_valid = 1'b1;
            pend_op    = op;
            pend_cin   = (op == OP_SUB) || (op == OP_SLT);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        q.delete();
        pend_valid = 1'b0;
        @(negedge clk);
        #1;
        chk(out_valid === 1'b0, "reset_flush_out_valid", N'(out_valid), '0);
        repeat (cycles - 1) @(negedge clk);
        rst = 1'b0;
        #1;
        chk(in_ready === 1'b1,       "reset_in_ready",     N'(in_ready), N'(1));
        chk(out_valid === 1'b0,      "reset_out_valid",    N'(out_valid), '0);
        chk(alu_a === '0 && alu_b === '0, "reset_alu_ab",  alu_a | alu_b, '0);
        chk(alu_operation === 4'b0000 && alu_carry_in === 1'b0, "reset_alu_op",
            N'({alu_operation, alu_carry_in}), '0);
        chk(out_result === '0 && {out_zero, out_overflow, out_illegal} === 3'b000, "reset_out",
            out_result | N'({out_zero, out_overflow, out_illegal}), '0);
    endtask

    task automatic directed(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] aluop,
                            input logic [2:0] f3, input logic f7, input exp_t e);
        bit acc;
        override = e;
        use_override = 1'b1;
        drive(1'b1, a, b, aluop, f3, f7, 1'b1, acc);
        use_override = 1'b0;
        chk(acc, "directed_accept", N'(acc), N'(1));
        drive(1'b0, '0, '0, 2'b00, 3'b000, 1'b0, 1'b1, acc);
        chk(out_valid === 1'b0, "latency_early", N'(out_valid), '0);
        drive(1'b0, '0, '0, 2'b00, 3'b000, 1'b0, 1'b1, acc);
        chk(out_valid === 1'b1, "latency_due", N'(out_valid), N'(1));
        drive(1'b0, '0, '0, 2'b00, 3'b000, 1'b0, 1'b1, acc);
    endtask

    function automatic logic [N-1:0] rand_opnd();
        logic [N-1:0] r;
        case ($urandom_range(0, 5))
            0:       r = '0;
            1:       r = {1'b1, {(N-1){1'b0}}};
            2:       r = '1;
            3:       r = {1'b0, {(N-1){1'b1}}};
            4:       r = N'($urandom_range(0, 20));
            default: r = {$urandom, $urandom};
        endcase
        return r;
    endfunction

    // Monitor: pops the scoreboard on every output handshake and checks stall stability.
    initial begin
        bit           prev_stall = 1'b0;
        logic [N-1:0] s_res;
        logic [2:0]   s_flags;
        exp_t         e;
        forever begin
            @(negedge clk);
            #2;
            if (prev_stall) begin
                chk(out_valid === 1'b1 && out_result === s_res
                    && {out_zero, out_overflow, out_illegal} === s_flags,
                    "stall_hold", out_result, s_res);
            end
            if (out_valid === 1'b1 && out_ready === 1'b1 && rst === 1'b0) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_output", out_result, '0);
                end else begin
                    e = q.pop_front();
                    n_out++;
                    chk(out_result === e.result, "out_result", out_result, e.result);
                    chk({out_zero, out_overflow, out_illegal} === {e.zero, e.ovf, e.ill},
                        "out_flags_zoi", N'({out_zero, out_overflow, out_illegal}),
                        N'({e.zero, e.ovf, e.ill}));
                    $display("OUT %0d result=%h zero=%b ovf=%b ill=%b", n_out, out_result,
                             out_zero, out_overflow, out_illegal);
                end
            end
            prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0) && (rst === 1'b0);
            s_res      = out_result;
            s_flags    = {out_zero, out_overflow, out_illegal};
        end
    end

    initial begin
        bit           acc;
        int           cyc;
        int           n_acc;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]   f3;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_aluop = 2'b00; in_funct3 = 3'b000; in_funct7b5 = 1'b0; out_ready = 1'b0;
        do_reset(2);

        directed(64'd5, 64'd7, 2'b10, 3'b000, 1'b0, '{64'd12, 1'b0, 1'b0, 1'b0});
        directed(64'h1234, 64'h1234, 2'b01, 3'b000, 1'b0, '{64'd0, 1'b1, 1'b0, 1'b0});
        directed(64'h8000_0000_0000_0000, 64'd1, 2'b10, 3'b010, 1'b0, '{64'd1, 1'b0, 1'b1, 1'b0});
        directed(64'd12, 64'd13, 2'b10, 3'b010, 1'b0, '{64'd1, 1'b0, 1'b0, 1'b0});
        directed(64'd13, 64'd12, 2'b10, 3'b010, 1'b0, '{64'd0, 1'b1, 1'b0, 1'b0});
        directed(64'd99, 64'd3, 2'b10, 3'b001, 1'b0, '{64'd0, 1'b1, 1'b0, 1'b1});

        // Four ADDs with the consumer stalled for the first three cycles.
        cyc = 0;
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            acc = 1'b0;
            while (!acc && cyc <= 40) begin
                drive(1'b1, N'(100 + i), N'(i), 2'b00, 3'b000, 1'b0, cyc >= 3, acc);
                if (acc) n_acc++;
                if (cyc == 2) begin
                    chk(in_ready === 1'b0, "bp_in_ready_low", N'(in_ready), '0);
                    chk(n_acc == 2, "bp_accepted_before_stall", N'(n_acc), N'(2));
                end
                cyc++;
            end
        end
        chk(n_acc == 4, "bp_all_accepted", N'(n_acc), N'(4));
        repeat (6) drive(1'b0, '0, '0, 2'b00, 3'b000, 1'b0, 1'b1, acc);
        chk(q.size() == 0, "bp_drained", N'(q.size()), '0);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            a = rand_opnd();
            b = ($urandom_range(0, 7) == 0) ? a : rand_opnd();
            case ($urandom_range(0, 4))
                0:       f3 = 3'b000;
                1:       f3 = 3'b111;
                2:       f3 = 3'b110;
                3:       f3 = 3'b010;
                default: f3 = 3'($urandom_range(0, 7));
            endcase
            drive($urandom_range(0, 3) != 0, a, b, 2'($urandom_range(0, 3)), f3,
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, acc);
        end
        repeat (6) drive(1'b0, '0, '0, 2'b00, 3'b000, 1'b0, 1'b1, acc);
        chk(q.size() == 0, "random_drained", N'(q.size()), '0);

        // Two items in flight, then reset: nothing may emerge afterwards.
        drive(1'b1, 64'd1, 64'd2, 2'b00, 3'b000, 1'b0, 1'b0, acc);
        drive(1'b1, 64'd3, 64'd4, 2'b00, 3'b000, 1'b0, 1'b0, acc);
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, '0, '0, 2'b00, 3'b000, 1'b0, 1'b1, acc);
            chk(out_valid === 1'b0, "post_reset_quiet", N'(out_valid), '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Producer-side controller for the 64-bit ALU in the EX stage.
- Accepts decoded instructions over a valid/ready handshake and translates ALUOp/funct fields into the ALU's 4-bit Operation code and carry-in.
- Drives the operand pair into the ALU from a registered issue stage, then captures the ALU result into a second register, together with the zero, overflow and set-less-than flags.
- Delivers result and flags downstream over a second valid/ready handshake.

Parameters:
- N, 64, datapath width of operands and result.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  issue stage can accept this cycle
- in_a  input  N  operand A
- in_b  input  N  operand B (register or immediate, already muxed)
- in_aluop  input  2  00 load/store, 01 branch, 10 R-type, 11 I-type
- in_funct3  input  3  instruction funct3
- in_funct7b5  input  1  instruction bit 30
- alu_a  output  N  operand A to ALU (registered)
- alu_b  output  N  operand B to ALU (registered)
- alu_operation  output  4  ALU Operation code (registered)
- alu_carry_in  output  1  ALU carry-in (registered)
- alu_result  input  N  ALU output, combinational from alu_a/alu_b/alu_operation
- alu_carry_out  input  1  ALU carry out of MSB
- out_valid  output  1  result register valid
- out_ready  input  1  downstream accepts
- out_result  output  N  final result
- out_zero  output  1  out_result == 0
- out_overflow  output  1  signed overflow of add/sub
- out_illegal  output  1  unsupported funct combination

Behaviour:
- Operation codes:
  - AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
  - NOR 1100 and NAND 1101 exist in the ALU but are never issued.
- Carry-in: 1 for SUB and SLT, 0 for all other operations.
- Decode:
  - aluop 00 -> ADD.
  - aluop 01 -> SUB.
  - aluop 10: funct3 000 -> ADD if f7b5=0, SUB if f7b5=1; 111 -> AND; 110 -> OR; 010 -> SLT.
  - aluop 11: funct3 000 -> ADD (f7b5 ignored); 111 -> AND; 110 -> OR; 010 -> SLT.
  - Any other combination sets illegal, issues AND, forces the result to 0 and raises out_illegal. The item still flows through the pipeline.
- Stage S1 (issue register):
  - Holds s1_valid, alu_a, alu_b, alu_operation, alu_carry_in, s1_illegal.
  - Loads on in_valid && in_ready.
  - in_ready = !s1_valid || s1_adv, where s1_adv = s1_valid && (!out_valid || out_ready).
- Stage S2 (result register):
  - Loads on s1_adv.
  - Clears out_valid on out_ready when there is no s1_adv.
  - Holds all out_* stable while out_valid && !out_ready.
- Flags are computed from the S1 operands and alu_result at the S2 load:
  - b_eff = alu_carry_in ? ~alu_b : alu_b.
  - ovf = (alu_a[N-1] == b_eff[N-1]) && (alu_result[N-1] != alu_a[N-1]), for ADD/SUB/SLT only, 0 otherwise.
  - slt = alu_result[N-1] ^ ovf.
  - out_result = SLT ? {N-1 zeros, slt} : (illegal ? 0 : alu_result).
  - out_zero is computed on the final out_result.
- Latency and throughput:
  - In-accept to out_valid is 2 cycles.
  - Full throughput is 1 item per cycle when out_ready is held high.
  - Backpressure propagates in the same cycle via in_ready; no item is dropped or duplicated.
- Simultaneous events: when S2 is full, out_ready=1 and S1 is valid, S2 drains and reloads in the same cycle, and S1 may also accept in that cycle.
- Reset:
  - s1_valid=0, out_valid=0, alu_a=alu_b=0, alu_operation=0000, alu_carry_in=0, out_* = 0.
  - in_ready=1 on the first cycle after reset.
  - Reset mid-operation discards all in-flight items.

Decomposition:
- Shared package holds the Operation code constants (AND, OR, ADD, SUB, SLT, NOR, NAND) and the ALUOp encodings.
- One sub-module, alu_op_decode: purely combinational {aluop, funct3, f7b5} -> {operation, carry_in, illegal}, instantiated ahead of S1.

Test Plan:
- ADD: reset, then aluop=10 f3=000 f7b5=0, A=5, B=7 -> alu_operation=0010, carry_in=0; 2 cycles later out_result=12, zero=0, overflow=0.
- SUB to zero: aluop=01, A=B=64'h1234 -> operation=0110, carry_in=1; out_result=0, zero=1.
- SLT with overflow: aluop=10 f3=010, A=64'h8000_0000_0000_0000, B=1 -> ALU wraps positive, overflow=1, out_result=1.
- SLT basic: A=12, B=13 -> out_result=1; then A=13, B=12 -> out_result=0.
- Illegal: aluop=10 f3=001 -> out_illegal=1, out_result=0, zero=1.
- Backpressure and reset:
  - Stream 4 ADDs with out_ready=0 for 3 cycles -> in_ready drops after 2 accepted, all 4 results emerge in order, out_* stable while stalled.
  - Assert rst with 2 items in flight -> out_valid=0 the next cycle, nothing emitted.
